ram_bist_ctrl: RTL and testbench

March-style built-in self-test initiator for the team's single-port synchronous RAM. It drives the RAM's write-enable, address and write-data pins, captures read data and compares it against expected values. It reports pass/fail, plus the first failing address, data and march element. It sits between a test-control register block and a single-port RAM instance, muxed onto the RAM pins during test.

---
 rtl/ram_bist_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: march BIST initiator (M0 write, M1/M2 read-check-invert, M3 read-check) for a single-port RAM.
// Optional BIST_ERR_COUNT_EN: adds err_count and runs every element to completion instead of aborting.
module ram_bist_ctrl #(
    parameter int          DATA_WIDTH = 8,
    parameter int          ADDR_WIDTH = 4,
    parameter int          READ_LAT   = 1,
    parameter logic [7:0]  PATTERN    = 8'h55
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [1:0]            fail_elem,
`ifdef BIST_ERR_COUNT_EN
    output logic [ADDR_WIDTH+2:0] err_count,
`endif
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_DONE} state_e;
    typedef enum logic [1:0] {PH_RD, PH_WAIT, PH_CHK} phase_e;

    localparam int CNT_W = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;
    localparam logic [DATA_WIDTH-1:0] PAT  = DATA_WIDTH'(PATTERN);
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    state_e                state_q, state_d;
    phase_e                phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_seen_q, err_seen_d;
    logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
    logic [1:0]            fail_elem_q, fail_elem_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [1:0]            cur_elem;
    logic                  mismatch;
`ifdef BIST_ERR_COUNT_EN
    logic [ADDR_WIDTH+2:0] err_cnt_q, err_cnt_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_RD;
            addr_q      <= '0;
            cnt_q       <= '0;
            err_seen_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_elem_q <= '0;
            we_q        <= 1'b0;
            raddr_q     <= '0;
            wdata_q     <= '0;
`ifdef BIST_ERR_COUNT_EN
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            err_seen_q  <= err_seen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            fail_elem_q <= fail_elem_d;
            we_q        <= we_d;
            raddr_q     <= raddr_d;
            wdata_q     <= wdata_d;
`ifdef BIST_ERR_COUNT_EN
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        err_seen_d  = err_seen_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        fail_elem_d = fail_elem_q;
`ifdef BIST_ERR_COUNT_EN
        err_cnt_d   = err_cnt_q;
`endif
        mismatch    = 1'b0;
        exp_data    = (state_q == S_M2) ? ~PAT : PAT;
        cur_elem    = (state_q == S_M1) ? 2'd1 : ((state_q == S_M2) ? 2'd2 : 2'd3);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_M0;
                    phase_d     = PH_RD;
                    addr_d      = '0;
                    err_seen_d  = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    fail_elem_d = '0;
`ifdef BIST_ERR_COUNT_EN
                    err_cnt_d   = '0;
`endif
                end
            end
            S_M0: begin
                if (addr_q == LAST) begin
                    state_d = S_M1;
                    phase_d = PH_RD;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_M1, S_M2, S_M3: begin
                case (phase_q)
                    PH_RD: begin
                        cnt_d   = '0;
                        phase_d = (READ_LAT == 1) ? PH_CHK : PH_WAIT;
                    end
                    PH_WAIT: begin
                        if (int'(cnt_q) == READ_LAT - 2) phase_d = PH_CHK;
                        else                             cnt_d   = cnt_q + 1'b1;
                    end
                    default: begin
                        mismatch = (ram_rdata != exp_data);
                        phase_d  = PH_RD;
                        // Element boundaries: M1 ends at LAST, M2 walks down to 0, M3 ends the march.
                        case (state_q)
                            S_M1: begin
                                if (addr_q == LAST) begin
                                    state_d = S_M2;
                                    addr_d  = LAST;
                                end else begin
                                    addr_d = addr_q + 1'b1;
                                end
                            end
                            S_M2: begin
                                if (addr_q == '0) state_d = S_M3;
                                else              addr_d  = addr_q - 1'b1;
                            end
                            default: begin
                                if (addr_q == LAST) begin
                                    state_d = S_DONE;
                                    addr_d  = '0;
                                end else begin
                                    addr_d = addr_q + 1'b1;
                                end
                            end
                        endcase
                        if (mismatch) begin
                            err_seen_d = 1'b1;
                            if (!err_seen_q) begin
                                fail_addr_d = addr_q;
                                fail_data_d = ram_rdata;
                                fail_elem_d = cur_elem;
                            end
`ifdef BIST_ERR_COUNT_EN
                            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
`else
                            state_d = S_DONE;
                            addr_d  = '0;
`endif
                        end
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_DONE) pass_d = ~err_seen_d;
        busy_d = (state_d inside {S_M0, S_M1, S_M2, S_M3});
        done_d = (state_d == S_DONE);

        // RAM pins are registered from the next state so they line up with the cycle they describe.
        we_d    = 1'b0;
        raddr_d = '0;
        wdata_d = '0;
        case (state_d)
            S_M0: begin
                we_d    = 1'b1;
                raddr_d = addr_d;
                wdata_d = PAT;
            end
            S_M1, S_M2, S_M3: begin
                raddr_d = addr_d;
                if (phase_d == PH_CHK && state_d != S_M3) begin
                    we_d    = 1'b1;
                    wdata_d = (state_d == S_M1) ? ~PAT : PAT;
                end
            end
            default: ;
        endcase
    end

    // Read data only arrives in the CHK cycle, so a failing word's write-back is masked live.
`ifdef BIST_ERR_COUNT_EN
    assign ram_we    = we_q;
    assign err_count = err_cnt_q;
`else
    assign ram_we    = we_q & ~mismatch;
`endif
    assign ram_addr  = raddr_q;
    assign ram_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign fail_elem = fail_elem_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: runs READ_LAT=1 and READ_LAT=2 controllers side by side on fault-injectable RAM models
// and compares each run against a behavioural march model.
module tb_ram_bist_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam logic [7:0] PAT = 8'h55;
`ifdef BIST_ERR_COUNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    logic          busyS[2], doneS[2], passS[2], ramWe[2];
    logic [AW-1:0] failAddr[2], ramAddr[2];
    logic [DW-1:0] failData[2], ramWdata[2], ramRdata[2];
    logic [1:0]    failElem[2];
`ifdef BIST_ERR_COUNT_EN
    logic [AW+2:0] errCount[2];
`endif

    logic [DW-1:0] mem[2][DEPTH];
    logic [DW-1:0] rdPipe;
    logic [DW-1:0] sa0[DEPTH];
    logic [DW-1:0] sa1[DEPTH];

    int busyCnt[2], doneCnt[2], stopAfter;
    bit overlap[2];
    int obsW[2][$];

    int expW[2][$];
    int expBusy[2], expErr[2], expFA[2], expFD[2], expFE[2];
    bit expPass[2];

    int testsRun = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    ram_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(1), .PATTERN(PAT)) dutL1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busyS[0]), .done(doneS[0]), .pass(passS[0]),
        .fail_addr(failAddr[0]), .fail_data(failData[0]), .fail_elem(failElem[0]),
`ifdef BIST_ERR_COUNT_EN
        .err_count(errCount[0]),
`endif
        .ram_we(ramWe[0]), .ram_addr(ramAddr[0]), .ram_wdata(ramWdata[0]), .ram_rdata(ramRdata[0])
    );

    ram_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(2), .PATTERN(PAT)) dutL2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busyS[1]), .done(doneS[1]), .pass(passS[1]),
        .fail_addr(failAddr[1]), .fail_data(failData[1]), .fail_elem(failElem[1]),
`ifdef BIST_ERR_COUNT_EN
        .err_count(errCount[1]),
`endif
        .ram_we(ramWe[1]), .ram_addr(ramAddr[1]), .ram_wdata(ramWdata[1]), .ram_rdata(ramRdata[1])
    );

    function automatic logic [DW-1:0] stuckVal(input int a, input logic [DW-1:0] v);
        return (v & ~sa0[a]) | sa1[a];
    endfunction

    // RAM models: latency 1 for dutL1, latency 2 for dutL2; stuck bits apply to stored words.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            if (ramWe[d]) mem[d][ramAddr[d]] <= stuckVal(int'(ramAddr[d]), ramWdata[d]);
        ramRdata[0] <= mem[0][ramAddr[0]];
        rdPipe      <= mem[1][ramAddr[1]];
        ramRdata[1] <= rdPipe;
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (doneCnt[d] < stopAfter) begin
                if (busyS[d]) busyCnt[d]++;
                if (busyS[d] && doneS[d]) overlap[d] = 1'b1;
                if (ramWe[d]) obsW[d].push_back(int'(ramAddr[d]) * 256 + int'(ramWdata[d]));
                if (doneS[d]) doneCnt[d]++;
            end
        end
    end

    task automatic checkOutput(input string tag, input int got, input int exp);
        testsRun++;
        if (got != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Behavioural march: an array of words walked element by element.
    task automatic modelRun(input int d, input int lat);
        logic [DW-1:0] m[DEPTH];
        logic [DW-1:0] ex, wv;
        int a, visited;
        bit stop;
        expW[d].delete();
        expErr[d] = 0; expFA[d] = 0; expFD[d] = 0; expFE[d] = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = stuckVal(i, PAT);
            expW[d].push_back(i * 256 + int'(PAT));
        end
        visited = 0;
        stop = 1'b0;
        for (int e = 1; e <= 3 && !stop; e++) begin
            for (int k = 0; k < DEPTH && !stop; k++) begin
                a  = (e == 2) ? DEPTH - 1 - k : k;
                ex = (e == 2) ? ~PAT : PAT;
                visited++;
                if (m[a] != ex) begin
                    if (expErr[d] == 0) begin
                        expFA[d] = a; expFD[d] = int'(m[a]); expFE[d] = e;
                    end
                    expErr[d]++;
                    if (!ERRCNT) stop = 1'b1;
                end
                if (!stop && e != 3) begin
                    wv   = (e == 1) ? ~PAT : PAT;
                    m[a] = stuckVal(a, wv);
                    expW[d].push_back(a * 256 + int'(wv));
                end
            end
        end
        expBusy[d] = DEPTH + visited * (lat + 1);
        expPass[d] = (expErr[d] == 0);
    endtask

    task automatic clearFaults();
        for (int i = 0; i < DEPTH; i++) begin
            sa0[i] = '0;
            sa1[i] = '0;
        end
    endtask

    task automatic clearCounters(input int limit);
        for (int d = 0; d < 2; d++) begin
            busyCnt[d] = 0;
            doneCnt[d] = 0;
            overlap[d] = 1'b0;
            obsW[d].delete();
        end
        stopAfter = limit;
    endtask

    task automatic applyStimulus(input int reps, input bit hold);
        int cyc;
        for (int d = 0; d < 2; d++) modelRun(d, d + 1);
        @(negedge clk);
        clearCounters(reps);
        start = 1'b1;
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
        cyc = 0;
        while (!(doneCnt[0] >= reps && doneCnt[1] >= reps) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checkOutput("run completes", int'(doneCnt[0] >= reps && doneCnt[1] >= reps), 1);
        cyc = 0;
        while ((busyS[0] || busyS[1]) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic checkRun(input string tag, input int reps);
        int n, bad;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s L%0d busy cycles", tag, d + 1), busyCnt[d], reps * expBusy[d]);
            checkOutput($sformatf("%s L%0d done pulses", tag, d + 1), doneCnt[d], reps);
            checkOutput($sformatf("%s L%0d busy/done overlap", tag, d + 1), int'(overlap[d]), 0);
            checkOutput($sformatf("%s L%0d pass", tag, d + 1), int'(passS[d]), int'(expPass[d]));
            checkOutput($sformatf("%s L%0d fail_addr", tag, d + 1), int'(failAddr[d]), expFA[d]);
            checkOutput($sformatf("%s L%0d fail_data", tag, d + 1), int'(failData[d]), expFD[d]);
            checkOutput($sformatf("%s L%0d fail_elem", tag, d + 1), int'(failElem[d]), expFE[d]);
`ifdef BIST_ERR_COUNT_EN
            checkOutput($sformatf("%s L%0d err_count", tag, d + 1), int'(errCount[d]), expErr[d]);
`endif
            n = expW[d].size();
            checkOutput($sformatf("%s L%0d write count", tag, d + 1), obsW[d].size(), reps * n);
            bad = -1;
            for (int i = 0; i < obsW[d].size() && i < reps * n; i++)
                if (bad < 0 && obsW[d][i] != expW[d][i % n]) bad = i;
            checkOutput($sformatf("%s L%0d first wrong write index", tag, d + 1), bad, -1);
        end
    endtask

    initial begin
        int cyc, nf, fa;
        clearFaults();
        clearCounters(1);
        #3;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("reset L%0d busy", d + 1), int'(busyS[d]), 0);
            checkOutput($sformatf("reset L%0d done", d + 1), int'(doneS[d]), 0);
            checkOutput($sformatf("reset L%0d pass", d + 1), int'(passS[d]), 0);
            checkOutput($sformatf("reset L%0d ram_we", d + 1), int'(ramWe[d]), 0);
            checkOutput($sformatf("reset L%0d ram_addr", d + 1), int'(ramAddr[d]), 0);
            checkOutput($sformatf("reset L%0d fail_addr", d + 1), int'(failAddr[d]), 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] clean march");
        applyStimulus(1, 1'b0);
        checkRun("clean", 1);

        $display("[TB] addr 5 bit0 stuck-at-0");
        sa0[5] = 8'h01;
        applyStimulus(1, 1'b0);
        checkRun("sa0@5", 1);

        $display("[TB] start held high across two runs");
        applyStimulus(2, 1'b1);
        checkRun("held start", 2);
        clearFaults();

        $display("[TB] reset during march");
        @(negedge clk);
        clearCounters(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busyCnt[0] < 40 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("reached busy cycle 40", int'(busyCnt[0] >= 40), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("async reset L%0d ram_we", d + 1), int'(ramWe[d]), 0);
            checkOutput($sformatf("async reset L%0d busy", d + 1), int'(busyS[d]), 0);
            checkOutput($sformatf("async reset L%0d pass", d + 1), int'(passS[d]), 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int d = 0; d < 2; d++)
            checkOutput($sformatf("no done after reset L%0d", d + 1), doneCnt[d], 0);
        applyStimulus(1, 1'b0);
        checkRun("after reset", 1);

        for (int r = 0; r < 8; r++) begin
            clearFaults();
            nf = $urandom_range(0, 2);
            for (int f = 0; f < nf; f++) begin
                fa = $urandom_range(0, DEPTH - 1);
                if ($urandom_range(0, 1) == 1) sa1[fa] = sa1[fa] | DW'(1 << $urandom_range(0, DW - 1));
                else                           sa0[fa] = sa0[fa] | DW'(1 << $urandom_range(0, DW - 1));
            end
            applyStimulus(1, 1'b0);
            checkRun($sformatf("random%0d", r), 1);
        end

        $display("[TB] bit0 stuck-at-0 at addresses 5 and 9");
        clearFaults();
        sa0[5] = 8'h01;
        sa0[9] = 8'h01;
        applyStimulus(1, 1'b0);
        checkRun("sa0@5,9", 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
